// File: rtl/pe_config_loader.sv
// Configuration sequencer for one PE tile: clears the serial config chain, shifts
// the incoming word stream into it LSB-first, optionally re-shifts to verify, then releases pe_reset.
module pe_config_loader #(
  parameter int CHAIN_LEN = 14,
  parameter int WORD_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_bit,
  output logic              cfg_shift,
  output logic              cfg_reset,
  input  logic              cfg_return,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              pe_reset
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_VERIFY, S_DONE} state_t;

  state_t               state, state_n;
  logic [WORD_W-1:0]    hold, hold_n;
  logic                 full, full_n;
  logic [IW-1:0]        idx, idx_n;
  logic [CW-1:0]        bcnt, bcnt_n;
  logic [CW-1:0]        vidx, vidx_n;
  logic [CHAIN_LEN-1:0] shadow, shadow_n;
  logic                 ver, ver_n;
  logic                 err_n, pe_rst_n;
  logic                 ready_n, shift_n, bit_n;

  always_comb begin
    state_n  = state;
    hold_n   = hold;
    full_n   = full;
    idx_n    = idx;
    bcnt_n   = bcnt;
    vidx_n   = vidx;
    shadow_n = shadow;
    ver_n    = ver;
    err_n    = error;
    pe_rst_n = pe_reset;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n  = S_CLEAR;
          ver_n    = verify_en;
          err_n    = 1'b0;
          pe_rst_n = 1'b1;
        end
      end
      S_CLEAR: begin
        state_n = S_LOAD;
        full_n  = 1'b0;
        bcnt_n  = '0;
        vidx_n  = '0;
      end
      S_LOAD: begin
        if (!full) begin
          if (word_valid) begin
            hold_n = word_in;
            full_n = 1'b1;
            idx_n  = '0;
          end
        end else begin
          shadow_n[bcnt] = hold[idx];
          bcnt_n         = bcnt + CW'(1);
          idx_n          = idx + IW'(1);
          // The chain-full test wins over word exhaustion so excess bits of the last word are dropped.
          if (bcnt == CW'(CHAIN_LEN - 1)) begin
            full_n  = 1'b0;
            state_n = ver ? S_VERIFY : S_DONE;
          end else if (idx == IW'(WORD_W - 1)) begin
            full_n = 1'b0;
          end
        end
      end
      S_VERIFY: begin
        if (cfg_return != shadow[vidx]) err_n = 1'b1;
        vidx_n = vidx + CW'(1);
        if (vidx == CW'(CHAIN_LEN - 1)) state_n = S_DONE;
      end
      S_DONE: begin
        state_n  = S_IDLE;
        pe_rst_n = error;
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are decoded from next-state values so the registered outputs line up with the state.
    ready_n = (state_n == S_LOAD) && !full_n;
    shift_n = ((state_n == S_LOAD) && full_n) || (state_n == S_VERIFY);
    bit_n   = 1'b0;
    if (state_n == S_VERIFY)  bit_n = shadow_n[vidx_n];
    else if (shift_n)         bit_n = hold_n[idx_n];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      hold       <= '0;
      full       <= 1'b0;
      idx        <= '0;
      bcnt       <= '0;
      vidx       <= '0;
      shadow     <= '0;
      ver        <= 1'b0;
      error      <= 1'b0;
      pe_reset   <= 1'b1;
      word_ready <= 1'b0;
      cfg_bit    <= 1'b0;
      cfg_shift  <= 1'b0;
      cfg_reset  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      hold       <= hold_n;
      full       <= full_n;
      idx        <= idx_n;
      bcnt       <= bcnt_n;
      vidx       <= vidx_n;
      shadow     <= shadow_n;
      ver        <= ver_n;
      error      <= err_n;
      pe_reset   <= pe_rst_n;
      word_ready <= ready_n;
      cfg_bit    <= bit_n;
      cfg_shift  <= shift_n;
      cfg_reset  <= (state_n == S_CLEAR);
      busy       <= (state_n != S_IDLE);
      done       <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_pe_config_loader.sv
// Randomized bench for pe_config_loader: a bench-side 14-bit chain model plus
// expected image/timing derived arithmetically from the word list.
module tb_pe_config_loader;
  localparam int CHAIN_LEN = 14;
  localparam int WORD_W    = 8;
  localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic              clk = 1'b0;
  logic              reset, start, verify_en, word_valid;
  logic [WORD_W-1:0] word_in;
  logic              word_ready, cfg_bit, cfg_shift, cfg_reset, cfg_return;
  logic              busy, done, error, pe_reset;

  logic [CHAIN_LEN-1:0] ch = '0;
  int                   sh_cnt = 0;
  bit                   fault_en;
  int                   fault_j;
  int                   n_tests = 0, n_fail = 0;
  logic [WORD_W-1:0]    words[NW+1];
  int                   stall[NW+1];

  always #5 clk = ~clk;

  pe_config_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .clk(clk), .reset(reset), .start(start), .verify_en(verify_en),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .cfg_bit(cfg_bit), .cfg_shift(cfg_shift), .cfg_reset(cfg_reset),
    .cfg_return(cfg_return), .busy(busy), .done(done), .error(error),
    .pe_reset(pe_reset)
  );

  // Chain model: head enters at the top, tail is bit 0.
  always @(posedge clk) begin
    if (cfg_reset) ch <= '0;
    else if (cfg_shift) ch <= {cfg_bit, ch[CHAIN_LEN-1:1]};
    if (start && !busy && !reset) sh_cnt <= 0;
    else if (cfg_shift) sh_cnt <= sh_cnt + 1;
  end

  assign cfg_return = ch[0] ^ (fault_en && (sh_cnt == CHAIN_LEN + fault_j));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string pre);
    check({pre, "_word_ready"}, 32'(word_ready), 0);
    check({pre, "_cfg_shift"},  32'(cfg_shift), 0);
    check({pre, "_cfg_reset"},  32'(cfg_reset), 0);
    check({pre, "_cfg_bit"},    32'(cfg_bit), 0);
    check({pre, "_busy"},       32'(busy), 0);
    check({pre, "_done"},       32'(done), 0);
    check({pre, "_error"},      32'(error), 0);
    check({pre, "_pe_reset"},   32'(pe_reset), 1);
  endtask

  // Called aligned 1 time unit after a rising edge; start is raised in cycle 0.
  task automatic run_cfg(input bit ver, input bit fault, input int fj, input bit dup_start);
    int c, wptr, nacc, pend, exp_done, done_at, resets, ready_cnt, first_ready, last_ready;
    int stalls_total, nshift, exp_last_ready;
    logic [31:0] lstream, vstream;
    logic [CHAIN_LEN-1:0] img;
    logic [WORD_W-1:0] w;
    bit seen_done, exp_err;

    img = '0;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      w = words[i / WORD_W];
      img[i] = w[i % WORD_W];
    end
    stalls_total = 0;
    for (int k = 0; k < NW; k++) stalls_total += stall[k];
    exp_done = 2 + NW + CHAIN_LEN + stalls_total + (ver ? CHAIN_LEN : 0);
    exp_last_ready = 2 + stalls_total + (NW - 1) * (WORD_W + 1);
    exp_err = ver && fault;
    fault_en = fault;
    fault_j = fj;

    wptr = 0; nacc = 0; pend = stall[0]; done_at = -1; resets = 0;
    ready_cnt = 0; first_ready = -1; last_ready = -1; nshift = 0;
    lstream = '0; vstream = '0; seen_done = 0; c = 0;
    while (!seen_done && c < 200) begin
      start = (c == 0) || (dup_start && c == 6);
      verify_en = (c == 0) ? ver : ~ver;
      word_in = words[wptr];
      if (word_ready && pend > 0) begin
        word_valid = 1'b0;
        pend--;
      end else begin
        word_valid = 1'b1;
      end
      @(negedge clk);
      if (c == 1) begin
        check("clear_pulse", 32'(cfg_reset), 1);
        check("error_cleared", 32'(error), 0);
        check("pe_reset_held", 32'(pe_reset), 1);
        check("busy", 32'(busy), 1);
      end
      if (cfg_reset) resets++;
      if (word_ready) begin
        ready_cnt++;
        if (first_ready < 0) first_ready = c;
        last_ready = c;
        if (word_valid) begin
          nacc++;
          if (wptr < NW) wptr++;
          pend = stall[wptr];
        end
      end
      if (cfg_shift) begin
        if (nshift < CHAIN_LEN) lstream[nshift] = cfg_bit;
        else if (nshift < 2 * CHAIN_LEN) vstream[nshift - CHAIN_LEN] = cfg_bit;
        nshift++;
      end
      if (done) begin
        seen_done = 1;
        done_at = c;
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    word_valid = 1'b1;
    check("done_cycle", done_at, exp_done);
    @(negedge clk);
    check("post_done", 32'(done), 0);
    check("post_busy", 32'(busy), 0);
    check("post_error", 32'(error), 32'(exp_err));
    check("post_pe_reset", 32'(pe_reset), 32'(exp_err));
    check("post_ready", 32'(word_ready), 0);
    check("clear_count", resets, 1);
    check("first_ready", first_ready, 2);
    check("last_ready", last_ready, exp_last_ready);
    check("ready_cycles", ready_cnt, NW + stalls_total);
    check("words_taken", nacc, NW);
    check("shift_count", nshift, ver ? 2 * CHAIN_LEN : CHAIN_LEN);
    check("load_stream", lstream, 32'(img));
    if (ver) check("verify_stream", vstream, 32'(img));
    check("chain_image", 32'(ch), 32'(img));
    @(posedge clk); #1;
    word_valid = 1'b0;
  endtask

  task automatic abort_test();
    int nsh;
    bit hit;
    start = 1'b1; verify_en = 1'b0; word_valid = 1'b1; word_in = words[0];
    nsh = 0; hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      if (c > 0) start = 1'b0;
      if (cfg_shift && nsh == 5) begin
        reset = 1'b1;
        hit = 1;
      end
      @(negedge clk);
      if (cfg_shift) nsh++;
      @(posedge clk); #1;
    end
    check("abort_reached", 32'(hit), 1);
    @(negedge clk);
    check_reset_vals("abort");
    reset = 1'b0;
    word_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; verify_en = 1'b0; word_valid = 1'b0; word_in = '0;
    fault_en = 0; fault_j = 0;
    for (int k = 0; k <= NW; k++) stall[k] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");
    @(posedge clk); #1;

    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h5A;
    run_cfg(0, 0, 0, 0);
    run_cfg(1, 0, 0, 0);
    run_cfg(1, 1, 5, 0);
    run_cfg(0, 0, 0, 0);
    stall[1] = 3;
    run_cfg(0, 0, 0, 0);
    stall[1] = 0;
    run_cfg(0, 0, 0, 1);
    abort_test();
    run_cfg(0, 0, 0, 0);

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k <= NW; k++) begin
        words[k] = WORD_W'($urandom);
        stall[k] = (k < NW) ? int'($urandom_range(0, 3)) : 0;
      end
      run_cfg(1'($urandom), 1'($urandom), int'($urandom_range(0, CHAIN_LEN - 1)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
